dac_frame_scheduler: RTL and testbench
======================================

# dac_frame_scheduler

Sequences and shares the AD5681R SPI master between several frame sources, such as the pushbutton voltage selector and future waveform or host-register sources. It grants one 24-bit frame at a time using round-robin arbitration and launches the frame with a start pulse. After the SPI master reports completion, it enforces a minimum SYNC-high gap and can optionally pulse LDAC to update the DAC output. It sits between the requesters and `SPI_MASTER` in `BeMicro_MAX10_top`.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters; legal range 1–8.
- `GAP_CYCLES`, default 4: minimum number of idle cycles between the end of one frame and the next start; 0 is legal.
- `LDAC_CYCLES`, default 2: width of the `ldac_n` low pulse; legal range ≥1.

Ports:
- `clk` in 1: system clock (SYS_CLK, 50 MHz).
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in NUM_REQ: per-requester frame request, level; held until granted.
- `req_data` in NUM_REQ*24: frame for requester i at bits [24i+23:24i].
- `gnt` out NUM_REQ: one-hot, single-cycle grant pulse; the frame is captured on this edge.
- `spi_start` out 1: single-cycle pulse telling the SPI master to begin a frame.
- `spi_data` out 24: latched frame; stable from `spi_start` until `spi_done`.
- `spi_done` in 1: single-cycle pulse from the SPI master when SYNC_n returns high.
- `ldac_n` out 1: to AD5681R_LDACn.
- `busy` out 1: high in every state except IDLE.
- `last_gnt` out 3: index of the most recently granted requester.

## Operation
- FSM states: IDLE, START, XFER, GAP, LDAC.
- IDLE: if any `req` bit is set, arbitrate round-robin starting at pointer `ptr`.
  - Assert `gnt[i]` for one cycle, latch `req_data[i]` into `spi_data`, set `last_gnt=i`, set `ptr=(i+1) mod NUM_REQ`, then go to START.
- START: `spi_start`=1 for one cycle, then go to XFER.
- XFER: wait for `spi_done`.
  - With `DAC_SCHED_LDAC_EN` defined, `spi_done` leads to LDAC.
  - Without it, `spi_done` leads to GAP.
  - No timeout: XFER waits indefinitely.
- LDAC: `ldac_n`=0 for exactly LDAC_CYCLES cycles, then go to GAP.
- GAP: count GAP_CYCLES cycles, then go to IDLE.
  - With GAP_CYCLES=0, GAP lasts one cycle and then goes to IDLE.
- `req` is ignored outside IDLE. A requester that drops `req` before its grant simply loses its turn; no error is raised.
- A `spi_done` outside XFER is ignored.
- Counter width is `$clog2(max(GAP_CYCLES,LDAC_CYCLES)+1)`. The counter saturates and never wraps.
- Pointer wrap: a grant to NUM_REQ-1 sets `ptr` to 0.

## Timing
- Reset values: state IDLE, `gnt`=0, `spi_start`=0, `spi_data`=24'h0, `ldac_n`=1, `busy`=0, `last_gnt`=0, `ptr`=0.
- A reset assertion mid-frame forces all of the above immediately (asynchronously) and aborts the frame.
- Request-to-start latency: with `req` high in IDLE at edge N, `gnt` is high in cycle N and `spi_start` is high in cycle N+1.
- Frame-to-frame spacing: the minimum number of cycles from `spi_done` to the next `spi_start` is
  - 2+GAP_CYCLES without LDAC, or
  - 2+GAP_CYCLES+LDAC_CYCLES with LDAC, for GAP_CYCLES≥1.
- `busy` rises in the cycle after the grant and falls when IDLE is re-entered.
- Simultaneous requests are served in round-robin order starting from `ptr`. No requester is starved while the others are held continuously.

## Configuration
- `DAC_SCHED_LDAC_EN` defined:
  - The LDAC state exists and `ldac_n` pulses low after every frame.
  - The top level drives AD5681R_LDACn from `ldac_n`.
- `DAC_SCHED_LDAC_EN` undefined:
  - The LDAC state is not built and `ldac_n` is a constant 1.
  - The DAC updates on SYNC rising edge (LDAC tied high).

## Structure
- Package `dac_sched_pkg` holds:
  - `FRAME_W`=24;
  - the state enum `dac_sched_state_t`;
  - AD5681R command nibble constants (WRITE_DAC_AND_INPUT=4'h3, WRITE_INPUT=4'h1, UPDATE_DAC=4'h2).
- One sub-module, `rr_arbiter`. It is combinational apart from its pointer register. Inputs: `req` and `ptr`. Outputs: one-hot grant and index.

## Test plan
- Reset, then `req`=2'b01 with `req_data[23:0]`=24'h300000 → `gnt`=01 for one cycle, `spi_start` in the next cycle, and `spi_data`=24'h300000 held until `spi_done`.
- Both requests held, `req_data` = 24'h340000 and 24'h38FF00, with the model returning `spi_done` 26 cycles after each start → frames alternate 0, 1, 0, 1 and `last_gnt` toggles.
- GAP_CYCLES=4, LDAC off, `spi_done` at cycle T with `req` held → next `spi_start` at exactly T+6.
- With `DAC_SCHED_LDAC_EN` and LDAC_CYCLES=2 → `ldac_n`=0 for exactly 2 cycles, starting the cycle after `spi_done`. Without the macro, `ldac_n` stays 1 throughout.
- Assert `rst_n`=0 during XFER → all outputs return to reset values immediately. After release with `req`=2'b11, requester 0 is granted first.
- Inject `spi_done` while in IDLE and while in GAP → no state change and no `spi_start`.

Source files
------------

// File: rtl/dac_frame_scheduler_pkg.sv
// Shared types and constants for the AD5681R frame scheduler.
// Frame width, state encoding and DAC command nibbles.
package dac_sched_pkg;

    localparam int FRAME_W = 24;
    localparam int IDX_W   = 3;

    localparam logic [3:0] WRITE_DAC_AND_INPUT = 4'h3;
    localparam logic [3:0] WRITE_INPUT         = 4'h1;
    localparam logic [3:0] UPDATE_DAC          = 4'h2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_XFER,
        S_GAP,
        S_LDAC
    } dac_sched_state_t;

endpackage

// File: rtl/dac_frame_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational pick starting at ptr,
// with ptr advancing past the winner whenever a grant is taken.
module rr_arbiter
    import dac_sched_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               upd,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    logic [IDX_W-1:0] ptr;
    logic             found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] &&
                    i == (int'(ptr) + k) % NUM_REQ) begin
                    gnt[i] = 1'b1;
                    idx    = IDX_W'(i);
                    found  = 1'b1;
                end
            end
        end
    end

    assign valid = |req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (upd) begin
            ptr <= (int'(idx) == NUM_REQ - 1) ? '0 : idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/dac_frame_scheduler.sv
// Round-robin scheduler sharing one AD5681R SPI master between requesters.
// Define DAC_SCHED_LDAC_EN to build the LDAC pulse state after each frame.
module dac_frame_scheduler
    import dac_sched_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int GAP_CYCLES  = 4,
    parameter int LDAC_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*FRAME_W-1:0] req_data,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       spi_start,
    output logic [FRAME_W-1:0]         spi_data,
    input  logic                       spi_done,
    output logic                       ldac_n,
    output logic                       busy,
    output logic [IDX_W-1:0]           last_gnt
);

    localparam int CNT_MAX = (GAP_CYCLES > LDAC_CYCLES) ?
                             GAP_CYCLES : LDAC_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    dac_sched_state_t   state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;
    logic               take;
    logic               gap_last;
    logic [FRAME_W-1:0] data_sel;

    assign take = (state == S_IDLE) && arb_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .upd   (take),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // Grant is a Mealy output of IDLE; masked while reset is held
    assign gnt       = (take && rst_n) ? arb_gnt : '0;
    assign spi_start = (state == S_START);
    assign busy      = (state != S_IDLE);
    assign gap_last  = (GAP_CYCLES == 0) ||
                       (int'(cnt) >= GAP_CYCLES - 1);

`ifdef DAC_SCHED_LDAC_EN
    logic ldac_last;
    assign ldac_last = (int'(cnt) >= LDAC_CYCLES - 1);
    assign ldac_n    = (state != S_LDAC);
`else
    assign ldac_n    = 1'b1;
`endif

    always_comb begin
        data_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) data_sel = req_data[i*FRAME_W +: FRAME_W];
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (arb_valid) state_nxt = S_START;
            S_START: state_nxt = S_XFER;
            S_XFER: begin
                if (spi_done) begin
`ifdef DAC_SCHED_LDAC_EN
                    state_nxt = S_LDAC;
`else
                    state_nxt = S_GAP;
`endif
                end
            end
`ifdef DAC_SCHED_LDAC_EN
            S_LDAC:  if (ldac_last) state_nxt = S_GAP;
`endif
            S_GAP:   if (gap_last) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // cnt restarts on every state change and saturates at CNT_MAX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            spi_data <= '0;
            last_gnt <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (int'(cnt) < CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (take) begin
                spi_data <= data_sel;
                last_gnt <= arb_idx;
            end
        end
    end

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Randomized self-checking bench for dac_frame_scheduler.
// Honours DAC_SCHED_LDAC_EN for the expected LDAC pulse width.
module tb_dac_frame_scheduler;

    localparam int N = 2;
    localparam int G = 4;
    localparam int L = 2;
`ifdef DAC_SCHED_LDAC_EN
    localparam int LE = L;
`else
    localparam int LE = 0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*24-1:0] req_data = '0;
    logic            spi_done = 1'b0;
    logic [N-1:0]    gnt;
    logic            spi_start;
    logic [23:0]     spi_data;
    logic            ldac_n;
    logic            busy;
    logic [2:0]      last_gnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_ptr = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dac_frame_scheduler #(
        .NUM_REQ     (N),
        .GAP_CYCLES  (G),
        .LDAC_CYCLES (L)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .spi_start (spi_start),
        .spi_data  (spi_data),
        .spi_done  (spi_done),
        .ldac_n    (ldac_n),
        .busy      (busy),
        .last_gnt  (last_gnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        req = '0;
        spi_done = 1'b0;
        step();
        step();
        #1;
        checks++;
        if (gnt !== '0) begin
            errors++; $display("FAIL reset_gnt got %b want 0", gnt);
        end
        checks++;
        if (spi_start !== 1'b0) begin
            errors++; $display("FAIL reset_start got %b want 0", spi_start);
        end
        checks++;
        if (spi_data !== 24'h0) begin
            errors++; $display("FAIL reset_data got %h want 0", spi_data);
        end
        checks++;
        if (ldac_n !== 1'b1) begin
            errors++; $display("FAIL reset_ldac got %b want 1", ldac_n);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got %b want 0", busy);
        end
        checks++;
        if (last_gnt !== 3'd0) begin
            errors++; $display("FAIL reset_last got %0d want 0", last_gnt);
        end
        rst_n = 1'b1;
        exp_ptr = 0;
    endtask

    task automatic test_single();
        logic [23:0] d;
        int bad;
        d = 24'h300000;
        step();
        req = 2'b01;
        req_data[23:0] = d;
        #1;
        checks++;
        if (gnt !== 2'b01 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_gnt got gnt=%b busy=%b want 01/0", gnt, busy);
        end
        step();
        req = '0;
        #1;
        checks++;
        if (gnt !== 2'b00 || spi_start !== 1'b1) begin
            errors++;
            $display("FAIL single_start got gnt=%b start=%b want 00/1",
                     gnt, spi_start);
        end
        checks++;
        if (spi_data !== d || last_gnt !== 3'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_latch got %h/%0d/%b want %h/0/1",
                     spi_data, last_gnt, busy, d);
        end
        exp_ptr = 1;
        bad = 0;
        for (int k = 1; k < 26; k++) begin
            step();
            #1;
            if (spi_start !== 1'b0 || spi_data !== d) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL single_hold got %0d bad cycles want 0", bad);
        end
        step();
        spi_done = 1'b1;
        #1;
        bad = 0;
        for (int c = 1; c <= LE + G + 1; c++) begin
            step();
            spi_done = 1'b0;
            #1;
            checks++;
            if (ldac_n !== ((c <= LE) ? 1'b0 : 1'b1)) begin
                errors++;
                $display("FAIL single_ldac c=%0d got %b", c, ldac_n);
            end
            checks++;
            if (busy !== ((c <= LE + G) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL single_busy c=%0d got %b", c, busy);
            end
            if (spi_start !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL single_nostart got %0d starts want 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0]  dat [2];
        logic [N-1:0] eg;
        int t_done, w, lows, wait_c;
        bit found;
        dat[0] = 24'h340000;
        dat[1] = 24'h38FF00;
        req_data = {dat[1], dat[0]};
        t_done = 0;
        step();
        req = 2'b11;
        #1;
        for (int f = 0; f < 6; f++) begin
            w = exp_ptr;
            eg = '0;
            eg[w] = 1'b1;
            checks++;
            if (gnt !== eg) begin
                errors++; $display("FAIL b2b_gnt f=%0d got %b want %b", f, gnt, eg);
            end
            step();
            #1;
            checks++;
            if (spi_start !== 1'b1 || spi_data !== dat[w] ||
                last_gnt !== 3'(w)) begin
                errors++;
                $display("FAIL b2b_frame f=%0d got %b/%h/%0d want 1/%h/%0d",
                         f, spi_start, spi_data, last_gnt, dat[w], w);
            end
            if (f > 0) begin
                checks++;
                if (cyc - t_done != 2 + G + LE) begin
                    errors++;
                    $display("FAIL b2b_spacing got %0d want %0d",
                             cyc - t_done, 2 + G + LE);
                end
            end
            exp_ptr = (w + 1) % N;
            for (int k = 1; k < 26; k++) step();
            step();
            spi_done = 1'b1;
            t_done = cyc;
            if (f == 5) req = '0;
            #1;
            lows = 0;
            found = 1'b0;
            wait_c = 0;
            while (!found && wait_c < 60) begin
                step();
                spi_done = 1'b0;
                #1;
                wait_c++;
                if (ldac_n === 1'b0) lows++;
                if (busy === 1'b0) found = 1'b1;
            end
            checks++;
            if (!found) begin
                errors++; $display("FAIL b2b_timeout got busy=%b want 0", busy);
            end
            checks++;
            if (lows != LE) begin
                errors++; $display("FAIL b2b_ldac got %0d low want %0d", lows, LE);
            end
        end
    endtask

    task automatic test_random();
        logic [23:0]  d [N];
        logic [N-1:0] r;
        logic [N-1:0] eg;
        int w, dly, c;
        bit found;
        for (int f = 0; f < 20; f++) begin
            r = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                d[i] = 24'($urandom);
                req_data[i*24 +: 24] = d[i];
            end
            req = r;
            #1;
            w = rr_pick(r, exp_ptr);
            eg = '0;
            eg[w] = 1'b1;
            checks++;
            if (gnt !== eg) begin
                errors++;
                $display("FAIL rand_gnt f=%0d req=%b got %b want %b", f, r, gnt, eg);
            end
            step();
            req = '0;
            #1;
            checks++;
            if (spi_start !== 1'b1 || spi_data !== d[w] ||
                last_gnt !== 3'(w)) begin
                errors++;
                $display("FAIL rand_frame f=%0d got %b/%h/%0d want 1/%h/%0d",
                         f, spi_start, spi_data, last_gnt, d[w], w);
            end
            exp_ptr = (w + 1) % N;
            dly = $urandom_range(1, 40);
            for (int k = 1; k < dly; k++) step();
            step();
            spi_done = 1'b1;
            #1;
            c = 0;
            found = 1'b0;
            while (!found && c < 80) begin
                step();
                spi_done = 1'b0;
                #1;
                c++;
                if (busy === 1'b0) found = 1'b1;
            end
            checks++;
            if (c != LE + G + 1) begin
                errors++;
                $display("FAIL rand_idle f=%0d got %0d cycles want %0d",
                         f, c, LE + G + 1);
            end
        end
    endtask

    task automatic test_spurious();
        int bad, c;
        bit found;
        step();
        spi_done = 1'b1;
        #1;
        step();
        spi_done = 1'b0;
        #1;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            if (busy !== 1'b0 || spi_start !== 1'b0) bad++;
            step();
            #1;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL spur_idle got %0d bad cycles want 0", bad);
        end
        req = 2'b10;
        #1;
        checks++;
        if (gnt !== 2'b10) begin
            errors++; $display("FAIL spur_gnt got %b want 10", gnt);
        end
        exp_ptr = 0;
        step();
        req = '0;
        for (int k = 0; k < 5; k++) step();
        spi_done = 1'b1;
        #1;
        c = 0;
        bad = 0;
        found = 1'b0;
        while (!found && c < 40) begin
            step();
            c++;
            spi_done = (c == LE + 2);
            #1;
            if (spi_start !== 1'b0) bad++;
            if (busy === 1'b0) found = 1'b1;
        end
        spi_done = 1'b0;
        checks++;
        if (c != LE + G + 1 || bad != 0) begin
            errors++;
            $display("FAIL spur_gap got %0d cycles %0d starts want %0d/0",
                     c, bad, LE + G + 1);
        end
    endtask

    task automatic test_reset_mid();
        int c;
        bit found;
        step();
        req = 2'b01;
        req_data[23:0] = 24'hABCDEF;
        #1;
        step();
        req = '0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (gnt !== '0 || spi_start !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_ctl got %b/%b/%b want 0/0/0", gnt, spi_start, busy);
        end
        checks++;
        if (spi_data !== 24'h0 || ldac_n !== 1'b1 || last_gnt !== 3'd0) begin
            errors++;
            $display("FAIL rstmid_data got %h/%b/%0d want 0/1/0",
                     spi_data, ldac_n, last_gnt);
        end
        req = 2'b11;
        #1;
        checks++;
        if (gnt !== '0) begin
            errors++; $display("FAIL rstmid_held got %b want 0", gnt);
        end
        step();
        rst_n = 1'b1;
        exp_ptr = 0;
        #1;
        checks++;
        if (gnt !== 2'b01) begin
            errors++; $display("FAIL rstmid_first got %b want 01", gnt);
        end
        step();
        req = '0;
        exp_ptr = 1;
        for (int k = 0; k < 3; k++) step();
        spi_done = 1'b1;
        #1;
        c = 0;
        found = 1'b0;
        while (!found && c < 40) begin
            step();
            spi_done = 1'b0;
            #1;
            c++;
            if (busy === 1'b0) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL rstmid_drain got busy=%b want 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_random();
        test_spurious();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule
